pipe_stall_ctrl: RTL

Central hazard and stall controller for the 5-stage MIPS pipeline (IF, ID, EXE, MEM, WB).
- Detects load-use and RAW hazards between ID and the downstream stages.
- Sequences multi-cycle SRAM accesses in MEM with a wait-state FSM.
- Produces the per-stage hold and flush (bubble) strobes consumed by the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers.
- Keeps a saturating stall-cycle counter for performance analysis.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_stall_ctrl_if.sv | 44 ++++
 rtl/pipe_stall_ctrl_hazard_detect.sv | 39 +++
 rtl/pipe_stall_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Optional feature macro: FORWARD_EN (see hazard_detect).
package pipe_pkg;

   // Memory wait-state FSM states
   typedef enum logic {
      MS_IDLE = 1'b0,
      MS_BUSY = 1'b1
   } mem_state_e;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-side signal bundle for the stall controller: hazard/memory
// status coming in, per-stage hold/flush strobes going out.
// Optional feature macro: FORWARD_EN (affects the controller, not this bundle).
interface pipe_stall_ctrl_if #(
   parameter int REG_W = pipe_pkg::REG_W
);
   logic [REG_W-1:0] id_src1;
   logic [REG_W-1:0] id_src2;
   logic             id_src2_valid;
   logic [REG_W-1:0] exe_dest;
   logic             exe_wb_en;
   logic             exe_mem_r_en;
   logic [REG_W-1:0] mem_dest;
   logic             mem_wb_en;
   logic             mem_r_en;
   logic             mem_w_en;
   logic             br_taken;

   logic             pc_hold;
   logic             if_id_hold;
   logic             id_exe_hold;
   logic             id_exe_flush;
   logic             if_id_flush;
   logic             exe_mem_hold;
   logic             mem_wb_flush;
   logic             mem_done;
   logic [31:0]      stall_cycles;

   // Pipeline datapath side
   modport master (
      output id_src1, id_src2, id_src2_valid, exe_dest, exe_wb_en, exe_mem_r_en,
             mem_dest, mem_wb_en, mem_r_en, mem_w_en, br_taken,
      input  pc_hold, if_id_hold, id_exe_hold, id_exe_flush, if_id_flush,
             exe_mem_hold, mem_wb_flush, mem_done, stall_cycles
   );

   // Stall controller side
   modport slave (
      input  id_src1, id_src2, id_src2_valid, exe_dest, exe_wb_en, exe_mem_r_en,
             mem_dest, mem_wb_en, mem_r_en, mem_w_en, br_taken,
      output pc_hold, if_id_hold, id_exe_hold, id_exe_flush, if_id_flush,
             exe_mem_hold, mem_wb_flush, mem_done, stall_cycles
   );
endinterface

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Combinational data-hazard detection between ID and the EXE/MEM stages.
// Optional feature macro: FORWARD_EN. With forwarding only a load in EXE
// can stall ID; without it any pending write to a source register stalls.
module hazard_detect
   import pipe_pkg::*;
#(
   parameter int REG_W = pipe_pkg::REG_W
) (
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_src2_valid,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   output logic             hazard
);
   logic exe_match;
   logic mem_match;
   logic lu;

   // Destination matches a register actually read by ID; register 0 never matches
   always_comb begin
      exe_match = (exe_dest != REG_W'(ZERO_REG)) &&
                  ((exe_dest == id_src1) || (id_src2_valid && (exe_dest == id_src2)));
      mem_match = (mem_dest != REG_W'(ZERO_REG)) &&
                  ((mem_dest == id_src1) || (id_src2_valid && (mem_dest == id_src2)));
      lu        = exe_mem_r_en && exe_wb_en && exe_match;
`ifdef FORWARD_EN
      // Forwarding covers everything except data still coming back from memory
      hazard    = lu || (1'b0 && mem_wb_en && mem_match);
`else
      // No forwarding: any in-flight write to a source register must drain
      hazard    = lu || (exe_wb_en && exe_match) || (mem_wb_en && mem_match);
`endif
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central hazard/stall controller for the 5-stage pipeline: memory wait-state
// FSM, hold/flush priority mux and a saturating stall-cycle counter.
// Optional feature macro: FORWARD_EN (selects the hazard rule in hazard_detect).
module pipe_stall_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_WAIT = 4,
   parameter int REG_W    = pipe_pkg::REG_W
) (
   input  logic          clk,
   input  logic          rst,
   pipe_stall_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(MEM_WAIT) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_WAIT - 1);

   mem_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      stall_cycles_q;
   logic [31:0]      stall_cycles_d;
   logic             mem_op;
   logic             mem_stall;
   logic             mem_done_c;
   logic             hazard;
   logic             pc_hold_c;

   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .id_src1       (bus.id_src1),
      .id_src2       (bus.id_src2),
      .id_src2_valid (bus.id_src2_valid),
      .exe_dest      (bus.exe_dest),
      .exe_wb_en     (bus.exe_wb_en),
      .exe_mem_r_en  (bus.exe_mem_r_en),
      .mem_dest      (bus.mem_dest),
      .mem_wb_en     (bus.mem_wb_en),
      .hazard        (hazard)
   );

   // Decode stall/done for the current access phase from FSM state
   always_comb begin
      mem_op     = bus.mem_r_en || bus.mem_w_en;
      mem_stall  = 1'b0;
      mem_done_c = 1'b0;
      case (state_q)
         MS_IDLE: begin
            if (mem_op) begin
               if (MEM_WAIT == 1) mem_done_c = 1'b1;
               else               mem_stall  = 1'b1;
            end
         end
         MS_BUSY: begin
            if (cnt_q < LAST_CNT) mem_stall  = 1'b1;
            else                  mem_done_c = 1'b1;
         end
         default: ;
      endcase
   end

   // Memory wait-state FSM: counts the cycles of one SRAM access
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MS_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            MS_IDLE: begin
               if (mem_op && (MEM_WAIT > 1)) begin
                  state_q <= MS_BUSY;
                  cnt_q   <= CNT_W'(1);
               end
            end
            MS_BUSY: begin
               if (cnt_q == LAST_CNT) begin
                  state_q <= MS_IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= MS_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Priority mux: memory stall freezes everything, then branch squash, then hazard bubble
   always_comb begin
      pc_hold_c        = 1'b0;
      bus.if_id_hold   = 1'b0;
      bus.id_exe_hold  = 1'b0;
      bus.id_exe_flush = 1'b0;
      bus.if_id_flush  = 1'b0;
      bus.exe_mem_hold = 1'b0;
      bus.mem_wb_flush = 1'b0;
      bus.mem_done     = 1'b0;
      if (!rst) begin
         bus.mem_done = mem_done_c;
         if (mem_stall) begin
            pc_hold_c        = 1'b1;
            bus.if_id_hold   = 1'b1;
            bus.id_exe_hold  = 1'b1;
            bus.exe_mem_hold = 1'b1;
            bus.mem_wb_flush = 1'b1;
         end else if (bus.br_taken) begin
            bus.if_id_flush  = 1'b1;
            bus.id_exe_flush = 1'b1;
         end else if (hazard) begin
            pc_hold_c        = 1'b1;
            bus.if_id_hold   = 1'b1;
            bus.id_exe_flush = 1'b1;
         end
      end
      bus.pc_hold = pc_hold_c;
   end

   // Next value of the saturating stall counter
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (pc_hold_c && (stall_cycles_q != 32'hFFFF_FFFF))
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   // Stall-cycle performance counter
   always_ff @(posedge clk) begin
      if (rst) stall_cycles_q <= '0;
      else     stall_cycles_q <= stall_cycles_d;
   end

   assign bus.stall_cycles = stall_cycles_q;

endmodule
